// File: rtl/uart_serial_bridge_pkg.sv
// uart_serial_bridge_pkg: shared types and constants for the serial bridge.
// Holds the TX/RX state encodings and the frame width.
package uart_serial_bridge_pkg;

   localparam int DATA_BITS = 8;
   localparam int BIT_W     = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HI
   } rx_state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_serial_bridge_if.sv
// uart_serial_bridge_if: processor-side byte port of the serial bridge.
// master = processor, slave = bridge.
interface uart_serial_bridge_if;
   logic [7:0] wr_data_in;
   logic       wr_en_in;
   logic       tx_ready_out;
   logic [7:0] rd_data_out;
   logic       rd_valid_out;
   logic       rd_en_in;

   modport master (
      output wr_data_in, wr_en_in, rd_en_in,
      input  tx_ready_out, rd_data_out, rd_valid_out
   );

   modport slave (
      input  wr_data_in, wr_en_in, rd_en_in,
      output tx_ready_out, rd_data_out, rd_valid_out
   );
endinterface

// File: rtl/uart_serial_bridge_sync_fifo.sv
// sync_fifo: synchronous show-ahead FIFO with wrap-bit pointers.
// dout reads as zero while empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] dout_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/uart_serial_bridge.sv
// uart_serial_bridge: byte-wide serial port peripheral.
// FIFO-buffered 8N1 UART transmitter and receiver.
module uart_serial_bridge
   import uart_serial_bridge_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic clock,
   input  logic reset,
   uart_serial_bridge_if.slave bus,
   output logic uart_tx_out,
   input  logic uart_rx_in,
   output logic tx_busy_out,
   output logic overrun_out,
   output logic frame_err_out,
   input  logic err_clr_in
);
   localparam int CNT_W = cnt_w(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] TOPB = BIT_W'(DATA_BITS - 1);

   logic                 tx_full, tx_empty, tx_pop, tx_last;
   logic [DATA_BITS-1:0] tx_dout;
   tx_state_e            tx_state_q;
   logic [CNT_W-1:0]     tx_cnt_q;
   logic [BIT_W-1:0]     tx_bit_q;
   logic [DATA_BITS-1:0] tx_shift_q;
   logic                 tx_line_q, tx_line_d;

   logic                 rx_full, rx_empty, rx_s, rx_last;
   logic [1:0]           rx_sync_q;
   logic                 rx_prev_q;
   rx_state_e            rx_state_q;
   logic [CNT_W-1:0]     rx_cnt_q;
   logic [BIT_W-1:0]     rx_bit_q;
   logic [DATA_BITS-1:0] rx_shift_q;
   logic                 rx_push_q;
   logic                 ovr_set, ferr_set;
   logic                 overrun_q, frame_err_q;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) tx_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (bus.wr_en_in),
      .din_i   (bus.wr_data_in),
      .pop_i   (tx_pop),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .dout_o  (tx_dout)
   );

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) rx_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (rx_push_q),
      .din_i   (rx_shift_q),
      .pop_i   (bus.rd_en_in),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .dout_o  (bus.rd_data_out)
   );

   assign bus.tx_ready_out = !tx_full;
   assign bus.rd_valid_out = !rx_empty;
   assign uart_tx_out      = tx_line_q;
   assign tx_busy_out      = (tx_state_q != TX_IDLE) || !tx_empty;
   assign overrun_out      = overrun_q;
   assign frame_err_out    = frame_err_q;

   assign tx_last = (tx_cnt_q == LAST);
   assign tx_pop  = !tx_empty &&
                    ((tx_state_q == TX_IDLE) ||
                     (tx_state_q == TX_STOP && tx_last));

   always_comb begin
      tx_line_d = 1'b1;
      unique case (tx_state_q)
         TX_START: tx_line_d = 1'b0;
         TX_DATA:  tx_line_d = tx_shift_q[0];
         default:  tx_line_d = 1'b1;
      endcase
   end

   // Line is registered from the state, so it lags the FSM by one clock.
   always_ff @(posedge clock) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_line_q <= tx_line_d;
         unique case (tx_state_q)
            TX_IDLE: begin
               tx_cnt_q <= '0;
               if (tx_pop) begin
                  tx_shift_q <= tx_dout;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               tx_cnt_q <= tx_last ? '0 : tx_cnt_q + ONE;
               if (tx_last) begin
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_DATA;
               end
            end
            TX_DATA: begin
               tx_cnt_q <= tx_last ? '0 : tx_cnt_q + ONE;
               if (tx_last) begin
                  tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
                  tx_bit_q   <= tx_bit_q + 1'b1;
                  if (tx_bit_q == TOPB) tx_state_q <= TX_STOP;
               end
            end
            TX_STOP: begin
               tx_cnt_q <= tx_last ? '0 : tx_cnt_q + ONE;
               if (tx_last) begin
                  tx_shift_q <= tx_dout;
                  tx_state_q <= tx_pop ? TX_START : TX_IDLE;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign rx_s     = rx_sync_q[1];
   assign rx_last  = (rx_cnt_q == LAST);
   assign ferr_set = (rx_state_q == RX_STOP) && rx_last && !rx_s;
   assign ovr_set  = rx_push_q && rx_full;

   // START samples MID clocks after the edge: the half-bit point.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_push_q  <= 1'b0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], uart_rx_in};
         rx_prev_q <= rx_s;
         rx_push_q <= 1'b0;
         unique case (rx_state_q)
            RX_IDLE: begin
               rx_cnt_q <= '0;
               if (rx_prev_q && !rx_s) rx_state_q <= RX_START;
            end
            RX_START: begin
               if (rx_cnt_q == MID) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + ONE;
               end
            end
            RX_DATA: begin
               rx_cnt_q <= rx_last ? '0 : rx_cnt_q + ONE;
               if (rx_last) begin
                  rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                  rx_bit_q   <= rx_bit_q + 1'b1;
                  if (rx_bit_q == TOPB) rx_state_q <= RX_STOP;
               end
            end
            RX_STOP: begin
               rx_cnt_q <= rx_last ? '0 : rx_cnt_q + ONE;
               if (rx_last) begin
                  rx_push_q  <= rx_s;
                  rx_state_q <= rx_s ? RX_IDLE : RX_WAIT_HI;
               end
            end
            RX_WAIT_HI: if (rx_s) rx_state_q <= RX_IDLE;
            default:    rx_state_q <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (ovr_set)         overrun_q <= 1'b1;
         else if (err_clr_in) overrun_q <= 1'b0;
         if (ferr_set)        frame_err_q <= 1'b1;
         else if (err_clr_in) frame_err_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_serial_bridge.sv
// tb_uart_serial_bridge: self-checking bench for the serial bridge.
// Table-driven vectors with TX/RX byte scoreboards.
module tb_uart_serial_bridge;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] data;
      logic       exp_ready;
      logic       accept;
   } tx_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       exp_ovr;
   } rx_vec_t;

   logic clock = 1'b0;
   logic reset;
   logic uart_tx, uart_rx, tx_busy, overrun, ferr, err_clr;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   int   starts[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   uart_serial_bridge_if bus();

   uart_serial_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .uart_tx_out   (uart_tx),
      .uart_rx_in    (uart_rx),
      .tx_busy_out   (tx_busy),
      .overrun_out   (overrun),
      .frame_err_out (ferr),
      .err_clr_in    (err_clr)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic checkn(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic wave_exp(input int i);
      logic [7:0] d;
      d = 8'h55;
      if (i < 2)  return 1'b1;
      if (i < 6)  return 1'b0;
      if (i < 38) return d[(i - 6) / 4];
      return 1'b1;
   endfunction

   task automatic write_byte(input logic [7:0] d);
      bus.wr_data_in = d;
      bus.wr_en_in   = 1'b1;
      tick();
      bus.wr_en_in   = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) tick();
      for (int b = 0; b < 8; b++) begin
         uart_rx = d[b];
         repeat (CPB) tick();
      end
      uart_rx = stop_bit;
      repeat (CPB) tick();
      uart_rx = 1'b1;
   endtask

   task automatic pop_rx();
      logic [7:0] exp;
      if (rxq.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rx_pop_model: expected queue empty, got %h required none", bus.rd_data_out);
      end else begin
         exp = rxq.pop_front();
         check1("rx_valid_before_pop", bus.rd_valid_out, 1'b1);
         check8("rx_data", bus.rd_data_out, exp);
      end
      bus.rd_en_in = 1'b1;
      tick();
      bus.rd_en_in = 1'b0;
   endtask

   task automatic wait_tx_idle(input int limit);
      int k;
      k = 0;
      while (tx_busy && k < limit) begin
         tick();
         k++;
      end
      check1("tx_idle_in_time", tx_busy, 1'b0);
   endtask

   // TX line monitor: decodes frames at bit centres and scores bytes.
   initial begin
      logic       prev;
      logic [7:0] b;
      logic       stp;
      int         st;
      prev = 1'b1;
      forever begin
         @(negedge clock);
         if (mon_en && prev === 1'b1 && uart_tx === 1'b0) begin
            st = cyc;
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clock);
            stp = uart_tx;
            if (mon_en) begin
               starts.push_back(st);
               check1("tx_stop_bit", stp, 1'b1);
               if (txq.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL tx_unexpected: got %h required no frame", b);
               end else begin
                  check8("tx_byte", b, txq.pop_front());
               end
            end
         end
         prev = uart_tx;
      end
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: got timeout required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      tx_vec_t tv[6];
      rx_vec_t rv[5];
      int      occ;

      tv[0] = '{8'h01, 1'b1, 1'b1};
      tv[1] = '{8'h02, 1'b1, 1'b1};
      tv[2] = '{8'h03, 1'b1, 1'b1};
      tv[3] = '{8'h04, 1'b1, 1'b1};
      tv[4] = '{8'h05, 1'b0, 1'b1};
      tv[5] = '{8'h06, 1'b0, 1'b0};
      rv[0] = '{8'h10, 1'b0};
      rv[1] = '{8'h11, 1'b0};
      rv[2] = '{8'h12, 1'b0};
      rv[3] = '{8'h13, 1'b0};
      rv[4] = '{8'h14, 1'b1};

      bus.wr_data_in = 8'h00;
      bus.wr_en_in   = 1'b0;
      bus.rd_en_in   = 1'b0;
      uart_rx = 1'b1;
      err_clr = 1'b0;
      reset   = 1'b0;

      // 1: reset state
      repeat (3) tick();
      reset = 1'b1;
      check1("rst_tx_line", uart_tx, 1'b1);
      check1("rst_tx_ready", bus.tx_ready_out, 1'b1);
      check1("rst_rd_valid", bus.rd_valid_out, 1'b0);
      check8("rst_rd_data", bus.rd_data_out, 8'h00);
      check1("rst_tx_busy", tx_busy, 1'b0);
      check1("rst_overrun", overrun, 1'b0);
      check1("rst_frame_err", ferr, 1'b0);
      tick();
      mon_en = 1'b1;

      // 2: single byte waveform
      txq.push_back(8'h55);
      write_byte(8'h55);
      for (int i = 0; i < 45; i++) begin
         check1($sformatf("tx_wave_%0d", i), uart_tx, wave_exp(i));
         tick();
      end
      wait_tx_idle(100);
      repeat (10) tick();

      // 3: burst into a full FIFO, frames back-to-back
      starts.delete();
      for (int j = 0; j < 6; j++) begin
         bus.wr_data_in = tv[j].data;
         bus.wr_en_in   = 1'b1;
         if (tv[j].accept) txq.push_back(tv[j].data);
         tick();
         check1($sformatf("tx_ready_w%0d", j + 1), bus.tx_ready_out, tv[j].exp_ready);
      end
      bus.wr_en_in = 1'b0;
      wait_tx_idle(400);
      repeat (10) tick();
      checkn("tx_frames", starts.size(), 5);
      for (int i = 1; i < starts.size(); i++)
         checkn($sformatf("tx_gap_%0d", i), starts[i] - starts[i-1], 10 * CPB);
      checkn("tx_drained", txq.size(), 0);

      // 4: one RX frame, then pop
      rxq.push_back(8'hA3);
      send_rx(8'hA3, 1'b1);
      begin
         int k;
         k = 0;
         while (!bus.rd_valid_out && k < 4) begin
            tick();
            k++;
         end
      end
      check1("rx_valid_in_time", bus.rd_valid_out, 1'b1);
      pop_rx();
      check1("rx_empty_after_pop", bus.rd_valid_out, 1'b0);

      // 5: glitch, then framing error and clear
      uart_rx = 1'b0;
      tick();
      uart_rx = 1'b1;
      repeat (12) tick();
      check1("glitch_no_push", bus.rd_valid_out, 1'b0);
      check1("glitch_no_ferr", ferr, 1'b0);
      send_rx(8'h5A, 1'b0);
      repeat (3) tick();
      check1("ferr_set", ferr, 1'b1);
      check1("ferr_no_push", bus.rd_valid_out, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check1("ferr_cleared", ferr, 1'b0);
      repeat (4) tick();

      // 6: overfill RX FIFO
      occ = 0;
      for (int i = 0; i < 5; i++) begin
         if (occ < DEPTH) begin
            rxq.push_back(rv[i].data);
            occ++;
         end
         send_rx(rv[i].data, 1'b1);
         repeat (3) tick();
         check1($sformatf("rx_ovr_f%0d", i), overrun, rv[i].exp_ovr);
         check1($sformatf("rx_valid_f%0d", i), bus.rd_valid_out, 1'b1);
      end
      check1("rx_no_ferr", ferr, 1'b0);
      for (int i = 0; i < DEPTH; i++) pop_rx();
      check1("rx_empty_after_drain", bus.rd_valid_out, 1'b0);
      checkn("rx_model_drained", rxq.size(), 0);

      // reset mid TX frame with both FIFOs holding data
      send_rx(8'h77, 1'b1);
      repeat (3) tick();
      check1("rx_refill_valid", bus.rd_valid_out, 1'b1);
      mon_en = 1'b0;
      write_byte(8'h3C);
      write_byte(8'hC3);
      repeat (9) tick();
      check1("tx_mid_low", uart_tx, 1'b0);
      check1("tx_mid_busy", tx_busy, 1'b1);
      reset = 1'b0;
      tick();
      check1("mid_rst_line", uart_tx, 1'b1);
      check1("mid_rst_ready", bus.tx_ready_out, 1'b1);
      check1("mid_rst_rd_valid", bus.rd_valid_out, 1'b0);
      check8("mid_rst_rd_data", bus.rd_data_out, 8'h00);
      check1("mid_rst_busy", tx_busy, 1'b0);
      check1("mid_rst_overrun", overrun, 1'b0);
      reset = 1'b1;
      repeat (20) tick();
      check1("post_rst_line", uart_tx, 1'b1);
      check1("post_rst_busy", tx_busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
